uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver stage fed by the baud-rate tick generator: consumes its single-cycle `tick` strobe (16 ticks per bit period) and the asynchronous `rx` line, and recovers 8N1 frames. Each completed frame is presented as a parallel byte with a one-cycle `rx_done` strobe to the debugger unit's command decoder. One clock domain; `rx` is the only asynchronous input.

## Interface
- `DBIT`, 8, data bits per frame, sent LSB first.
- `SB_TICK`, 16, ticks spent in the stop bit (16 = 1 stop bit).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tick`  in  1  oversampling strobe from the baud-rate generator.
  - One `clk` cycle wide.
  - 16 per bit period.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `dout`  out  DBIT  last received byte; holds until the next frame completes.
- `rx_done`  out  1  one-cycle pulse when `dout` is updated.
- `frame_err`  out  1  stop-bit value of the last frame was 0.
  - Valid with `rx_done`.
  - Held until the next frame completes.

## Operation
- `rx` passes through a 2-flop synchronizer (both flops reset to 1). All FSM decisions use the synchronized value `rx_s`.
- Internal registers:
  - tick counter `s`, 4 bits, wraps 15 -> 0.
  - bit counter `n`, `$clog2(DBIT)` bits.
  - shift register `b`, DBIT bits.
- FSM states:
  - IDLE:
    - `rx_s`==0 -> START, `s`<=0. This is the only transition not gated by `tick`.
  - START:
    - On `tick` with `s`==7 (mid start bit): if `rx_s`==0 -> DATA, `s`<=0, `n`<=0.
    - On `tick` with `s`==7 and `rx_s`==1 (false start/glitch): -> IDLE with no output change.
    - On other ticks: `s`++.
  - DATA:
    - On `tick` with `s`==15: `b`<={`rx_s`, `b`[DBIT-1:1]}, `s`<=0.
    - Then if `n`==DBIT-1 -> STOP, else `n`++.
    - On other ticks: `s`++.
  - STOP:
    - On `tick` with `s`==SB_TICK-1: `dout`<=`b`, `frame_err`<=~`rx_s`, `rx_done`<=1, -> IDLE.
    - On other ticks: `s`++.
- `rx_done` is deasserted in every cycle except the one following the completing tick.
- A frame with a bad stop bit still updates `dout` and pulses `rx_done`, with `frame_err`=1.
- Cycles without `tick` leave `s`, `n`, `b` and the state unchanged, except the IDLE -> START transition.
- Reset (asynchronous, any state, including mid-frame):
  - state=IDLE; `s`, `n`, `b` = 0.
  - `dout`=0, `rx_done`=0, `frame_err`=0.
  - Synchronizer flops = 1.
  - After release, a line already low is treated as a new start edge.

## Timing
- Synchronizer latency: a falling `rx` edge is visible as `rx_s` 2 `clk` edges later.
- Start detection: START is entered 1 cycle after `rx_s` goes low.
- Sampling points: tick 8 of the start bit, then every 16 ticks, i.e. mid-bit for each data bit and the stop bit.
- Frame completion:
  - `rx_done`, `dout` and `frame_err` change on the `clk` edge that registers the STOP completion tick.
  - That is 16*(1+DBIT)+SB_TICK-8 ticks after the START entry, = 152 ticks with defaults.
- Back-to-back frames: IDLE is re-entered mid stop bit, so a start bit immediately following the stop bit is detected with no lost frame.
- `tick` and `rx` edges may coincide; `rx_s` is sampled as registered in that cycle.
- `tick` high for more than one cycle is outside the contract.

## Test plan
- Reset and idle:
  - Hold `rst`=0, then release with `rx`=1 and `tick` every 4 clocks.
  - Outputs stay `dout`=0x00, `rx_done`=0, `frame_err`=0 for 1000 cycles.
- Single frame:
  - Send 0x55, then 0xA3 (LSB first, 1 stop bit, 16 ticks/bit).
  - Exactly one `rx_done` pulse per frame, `dout`=0x55 then 0xA3, `frame_err`=0.
  - `dout` holds 0xA3 afterwards.
- Glitch rejection:
  - Drive `rx` low for 3 ticks, then high.
  - FSM returns to IDLE, no `rx_done`, `dout` unchanged.
  - A following 0x3C frame is received correctly.
- Framing error:
  - Send 0xF0 with the stop bit held 0.
  - `rx_done` pulses, `dout`=0xF0, `frame_err`=1.
  - A next valid 0x0F frame clears `frame_err` to 0.
- Reset mid-frame:
  - Assert `rst` during data bit 4 of 0xFF.
  - All outputs 0 immediately and no `rx_done`.
  - After release, 0x81 is received correctly.
- Back-to-back:
  - Send 0x00, 0xFF, 0x5A with no idle gap between stop and start bits.
  - Three `rx_done` pulses with those values in order.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver driven by a 16x oversampling tick strobe.
// Recovers one byte per frame and flags a zero stop bit as a framing error.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done,
  output logic            frame_err
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_d;
  logic [3:0]      s, s_d;
  logic [NW-1:0]   n, n_d;
  logic [DBIT-1:0] b, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            fe_q, fe_d;
  logic            rx_meta, rx_s;

  // Reset to the idle line level so leaving reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      dout_q <= '0;
      done_q <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      state  <= state_d;
      s      <= s_d;
      n      <= n_d;
      b      <= b_d;
      dout_q <= dout_d;
      done_q <= done_d;
      fe_q   <= fe_d;
    end
  end

  // NOTE: every signal gets a hold/default value first so no latch is inferred.
  always_comb begin
    state_d = state;
    s_d     = s;
    n_d     = n;
    b_d     = b;
    dout_d  = dout_q;
    fe_d    = fe_q;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s == 4'd7) begin
            // Mid start bit: a high line here was only a glitch.
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == 4'd15) begin
            b_d = {rx_s, b[DBIT-1:1]};
            s_d = '0;
            if (n == N_LAST) state_d = STOP;
            else             n_d     = n + NW'(1);
          end else begin
            s_d = s + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s == S_STOP) begin
            dout_d  = b;
            fe_d    = ~rx_s;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout      = dout_q;
    rx_done   = done_q;
    frame_err = fe_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: reset, frames, glitch, framing error,
// mid-frame reset and back-to-back frames, with 4 clocks per tick.
module tb_uart_rx;

  logic       clk, rst, tick, rx;
  logic [7:0] dout;
  logic       rx_done, frame_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] done_q[$];
  logic       fe_q[$];

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx),
    .dout(dout), .rx_done(rx_done), .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle tick every 4 clocks, changed on the falling edge.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  // Records every rx_done cycle; a stretched pulse shows up as an extra entry.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rx_done === 1'b1) begin
        done_q.push_back(dout);
        fe_q.push_back(frame_err);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int k);
    repeat (k) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int stop_ticks, input logic stop_val);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = stop_val;
    wait_ticks(stop_ticks);
    rx = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic fe);
    check({tag, "_pulses"}, 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) begin
      check({tag, "_dout"}, 32'(done_q.pop_front()), 32'(d));
      check({tag, "_ferr"}, 32'(fe_q.pop_front()), 32'(fe));
    end
    done_q.delete();
    fe_q.delete();
  endtask

  initial begin
    int bad;
    rst = 1'b0;
    rx  = 1'b1;

    // Reset and idle
    repeat (5) @(negedge clk);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_done", 32'(rx_done), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    rst = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if (dout !== 8'h00 || rx_done !== 1'b0 || frame_err !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);
    check("idle_pulses", 32'(done_q.size()), 32'd0);
    wait_ticks(4);

    // Single frames
    send_frame(8'h55, 16, 1'b1);
    wait_ticks(16);
    expect_frame("f55", 8'h55, 1'b0);
    send_frame(8'hA3, 16, 1'b1);
    wait_ticks(16);
    expect_frame("fA3", 8'hA3, 1'b0);
    wait_ticks(64);
    check("hold_A3", 32'(dout), 32'hA3);
    check("hold_pulses", 32'(done_q.size()), 32'd0);

    // Glitch rejection
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(32);
    check("glitch_pulses", 32'(done_q.size()), 32'd0);
    check("glitch_dout", 32'(dout), 32'hA3);
    send_frame(8'h3C, 16, 1'b1);
    wait_ticks(16);
    expect_frame("f3C", 8'h3C, 1'b0);

    // Framing error: stop low long enough to be sampled, then released
    send_frame(8'hF0, 12, 1'b0);
    wait_ticks(24);
    expect_frame("fF0", 8'hF0, 1'b1);
    check("ferr_held", 32'(frame_err), 32'd1);
    send_frame(8'h0F, 16, 1'b1);
    wait_ticks(16);
    expect_frame("f0F", 8'h0F, 1'b0);

    // Reset during data bit 4 of 0xFF
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(64 + 8);
    rst = 1'b0;
    #1;
    check("mid_rst_dout", 32'(dout), 32'h00);
    check("mid_rst_done", 32'(rx_done), 32'd0);
    check("mid_rst_ferr", 32'(frame_err), 32'd0);
    wait_ticks(8 + 48 + 16);
    rst = 1'b1;
    wait_ticks(32);
    check("mid_rst_pulses", 32'(done_q.size()), 32'd0);
    check("mid_rst_hold", 32'(dout), 32'h00);
    send_frame(8'h81, 16, 1'b1);
    wait_ticks(16);
    expect_frame("f81", 8'h81, 1'b0);

    // Back-to-back frames
    send_frame(8'h00, 16, 1'b1);
    send_frame(8'hFF, 16, 1'b1);
    send_frame(8'h5A, 16, 1'b1);
    wait_ticks(16);
    check("b2b_pulses", 32'(done_q.size()), 32'd3);
    if (done_q.size() == 3) begin
      check("b2b_0", 32'(done_q[0]), 32'h00);
      check("b2b_1", 32'(done_q[1]), 32'hFF);
      check("b2b_2", 32'(done_q[2]), 32'h5A);
      check("b2b_ferr", 32'({fe_q[0], fe_q[1], fe_q[2]}), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
